// File: rtl/memory_access_stage_pkg.sv
// Shared types and constants for the memory access stage and its lane aligner.
package memory_access_stage_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Number of ACCESS cycles without ack before the access is abandoned.
  localparam int         MEM_TIMEOUT = 16;
  // Down-counter preload; terminal count 0 falls on the MEM_TIMEOUT-th cycle.
  localparam logic [3:0] TMO_LOAD    = 4'(MEM_TIMEOUT - 1);

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_LANE0 = 4'b0001;

  // Byte-enable for a single little-endian byte lane.
  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    return BE_LANE0 << lane;
  endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data memory bus between the memory access stage (master) and memory (slave).
interface memory_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/memory_access_stage_lane_align.sv
// Byte-lane steering: store replication, byte enables and load extraction/rotation.
module mem_lane_align
  import memory_access_stage_pkg::*;
(
  input  logic        i_byte,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_load_data
);

  logic [31:0] w_rot;

  // Rotate read data right by 8*lane so the addressed byte lands in bits [7:0].
  always_comb begin
    w_rot = i_rdata;
    case (i_lane)
      2'd1:    w_rot = {i_rdata[7:0],  i_rdata[31:8]};
      2'd2:    w_rot = {i_rdata[15:0], i_rdata[31:16]};
      2'd3:    w_rot = {i_rdata[23:0], i_rdata[31:24]};
      default: w_rot = i_rdata;
    endcase
  end

  // Byte accesses use one lane; word accesses use all four.
  always_comb begin
    o_wdata     = i_byte ? {4{i_store_data[7:0]}} : i_store_data;
    o_be        = i_byte ? lane_be(i_lane) : BE_WORD;
    o_load_data = i_byte ? {24'h0, w_rot[7:0]} : w_rot;
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: ALU passthrough, load/store with stall,
// base-register writeback and a bounded wait for the memory ack.
//
// state     | meaning
// ST_IDLE   | no access in flight; ALU results pass straight to MEM/WB
// ST_ACCESS | dmem_req held high, waiting for dmem_ack or timeout
module memory_access_stage
  import memory_access_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  mem_op_in,
  input  logic                  load_in,
  input  logic                  byte_in,
  input  logic                  pre_in,
  input  logic                  wb_base_in,
  input  logic [31:0]           base_in,
  input  logic [31:0]           addr_in,
  input  logic [31:0]           store_data_in,
  input  logic [31:0]           alu_result_in,
  input  logic [3:0]            rd_in,
  input  logic [3:0]            rn_in,
  input  logic                  reg_we_in,
  output logic                  stall_out,
  memory_access_stage_if.master dmem,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [3:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic                  base_we,
  output logic [3:0]            base_rn,
  output logic [31:0]           base_data,
  output logic                  mem_fault
);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_tmo_cnt;
  logic        w_access;
  logic        w_start;
  logic        w_done;
  logic        w_timeout;
  logic        w_base_wb;
  logic        w_base_hazard;
  logic [31:0] w_ea;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic [3:0]  w_be;

  assign w_access      = (r_state == ST_ACCESS);
  assign w_start       = valid_in & mem_op_in;
  assign w_done        = w_access & dmem.dmem_ack;
  assign w_timeout     = w_access & ~dmem.dmem_ack & (r_tmo_cnt == 4'd0);
  assign w_ea          = pre_in ? addr_in : base_in;
  assign w_base_wb     = wb_base_in | ~pre_in;
  // A load into the base register itself keeps the loaded value.
  assign w_base_hazard = load_in & (rd_in == rn_in);

  mem_lane_align u_lane_align (
    .i_byte       (byte_in),
    .i_lane       (w_ea[1:0]),
    .i_store_data (store_data_in),
    .i_rdata      (dmem.dmem_rdata),
    .o_wdata      (w_wdata),
    .o_be         (w_be),
    .o_load_data  (w_load_data)
  );

  // Bus outputs are qualified by the registered state so they are quiet outside ACCESS.
  assign dmem.dmem_req   = w_access;
  assign dmem.dmem_we    = w_access & ~load_in;
  assign dmem.dmem_addr  = w_access ? {w_ea[31:2], 2'b00} : 32'h0;
  assign dmem.dmem_wdata = (w_access & ~load_in) ? w_wdata : 32'h0;
  assign dmem.dmem_be    = w_access ? w_be : 4'h0;

  // Next-state and stall; stall releases on ack or timeout so upstream can advance.
  always_comb begin
    w_next_state = r_state;
    stall_out    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next_state = ST_ACCESS;
          stall_out    = reset;
        end
      end
      ST_ACCESS: begin
        stall_out = ~(dmem.dmem_ack | w_timeout);
        if (dmem.dmem_ack | w_timeout) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register and timeout down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_tmo_cnt <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (!w_access && w_start) begin
        r_tmo_cnt <= TMO_LOAD;
      end else if (w_access && (w_next_state == ST_ACCESS)) begin
        r_tmo_cnt <= r_tmo_cnt - 4'd1;
      end else begin
        r_tmo_cnt <= 4'd0;
      end
    end
  end

  // One-cycle MEM/WB results, base writeback and fault pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= 4'd0;
      wb_data   <= 32'h0;
      base_we   <= 1'b0;
      base_rn   <= 4'd0;
      base_data <= 32'h0;
      mem_fault <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= 4'd0;
      wb_data   <= 32'h0;
      base_we   <= 1'b0;
      base_rn   <= 4'd0;
      base_data <= 32'h0;
      mem_fault <= 1'b0;
      if (!w_access && valid_in && !mem_op_in) begin
        wb_valid <= 1'b1;
        wb_we    <= reg_we_in;
        wb_rd    <= rd_in;
        wb_data  <= alu_result_in;
      end else if (w_done) begin
        wb_valid <= 1'b1;
        wb_we    <= reg_we_in & load_in;
        wb_rd    <= rd_in;
        wb_data  <= load_in ? w_load_data : 32'h0;
        if (w_base_wb && !w_base_hazard) begin
          base_we   <= 1'b1;
          base_rn   <= rn_in;
          base_data <= addr_in;
        end
      end else if (w_timeout) begin
        mem_fault <= 1'b1;
      end
    end
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 Port order and names SHALL be as listed in REQ-002..REQ-008.
- One clock, clk.
- Reset is asynchronous and active-low, named reset.
REQ-002 Clock and reset ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
REQ-003 Instruction inputs from the EX/MEM register, each `in`:
- valid_in  1  instruction present.
- mem_op_in  1  load/store (0 = ALU passthrough).
- load_in  1  1 = load, 0 = store.
- byte_in  1  1 = byte, 0 = word.
- pre_in  1  1 = pre-index, 0 = post-index.
- wb_base_in  1  base writeback requested.
REQ-004 Data inputs, each `in`:
- base_in  32  base register value.
- addr_in  32  base±offset.
- store_data_in  32.
- alu_result_in  32.
- rd_in  4.
- rn_in  4.
- reg_we_in  1.
REQ-005 Pipeline control output:
- stall_out  out  1  freeze upstream stages.
REQ-006 Data memory bus:
- dmem_req  out  1.
- dmem_we  out  1.
- dmem_addr  out  32.
- dmem_wdata  out  32.
- dmem_be  out  4.
- dmem_rdata  in  32.
- dmem_ack  in  1.
REQ-007 Result outputs to MEM/WB, each `out`:
- wb_valid  1.
- wb_we  1.
- wb_rd  4.
- wb_data  32.
REQ-008 Base writeback and fault outputs, each `out`:
- base_we  1.
- base_rn  4.
- base_data  32.
- mem_fault  1  one-cycle pulse.

Function
REQ-009 FSM states SHALL be IDLE and ACCESS.
- IDLE→ACCESS when valid_in & mem_op_in.
- ACCESS→IDLE on dmem_ack or on timeout.
REQ-010 ALU passthrough (valid_in & !mem_op_in in IDLE): next edge SHALL register the following, with no stall:
- wb_valid=1.
- wb_data=alu_result_in.
- wb_rd=rd_in.
- wb_we=reg_we_in.
REQ-011 Effective address SHALL be addr_in when pre_in=1, else base_in.
REQ-012 dmem_addr SHALL be {EA[31:2],2'b00}.
REQ-013 Memory request signals:
- dmem_req SHALL be registered and high for the whole of ACCESS.
- dmem_we SHALL equal !load_in.
REQ-014 Stall rules:
- stall_out SHALL be high combinationally in IDLE when valid_in & mem_op_in.
- stall_out SHALL be high throughout ACCESS.
- stall_out SHALL drop in the cycle dmem_ack is sampled high.
- Inputs are held stable by upstream while stall_out=1.
REQ-015 An ack in the first ACCESS cycle SHALL complete the access (zero wait states).
REQ-016 Byte store SHALL drive:
- dmem_wdata = store_data_in[7:0] replicated ×4.
- dmem_be = 1<<EA[1:0].
REQ-017 Word store SHALL drive dmem_be=4'b1111.
REQ-018 Byte load SHALL set wb_data = zero-extended byte lane EA[1:0] (little-endian).
REQ-019 Word load SHALL set wb_data = dmem_rdata rotated right by 8*EA[1:0].
REQ-020 Completion: the edge after ack SHALL register the following, pulsed for 1 cycle:
- wb_valid=1.
- wb_we = reg_we_in & load_in.
- wb_rd=rd_in.
REQ-021 Base writeback SHALL occur at completion when wb_base_in=1 or pre_in=0:
- base_we=1.
- base_rn=rn_in.
- base_data=addr_in.
REQ-022 Load with rd_in==rn_in and base writeback: load data SHALL win and base_we SHALL be 0.
REQ-023 Timeout: a 4-bit counter SHALL count ACCESS cycles without ack. On the 16th cycle without ack:
- dmem_req drops.
- mem_fault pulses 1 cycle.
- wb_valid=0, wb_we=0, base_we=0.
- FSM returns to IDLE.
REQ-024 valid_in=0 in IDLE SHALL produce wb_valid=0, wb_we=0, base_we=0.

Reset
REQ-025 While reset=0 the following SHALL hold:
- FSM is in IDLE and the counter is 0.
- All outputs are 0, including dmem_req and stall_out.
REQ-026 Reset asserted mid-ACCESS SHALL drop dmem_req asynchronously and discard the access; no write-back follows.

Structure
REQ-027 A shared package SHALL hold:
- the state enum;
- MEM_TIMEOUT=16;
- the byte-enable/lane constants.
REQ-028 Lane replication, byte enables, load extraction and rotation SHALL live in one combinational sub-module, mem_lane_align.

Verification
REQ-029 ALU op, alu_result_in=0x12345678, rd_in=3 -> next cycle wb_valid=1, wb_rd=3, wb_data=0x12345678, stall_out never high.
REQ-030 Byte load, pre, addr_in=0x103, rdata=0xAABBCCDD, ack after 2 cycles -> dmem_addr=0x100, wb_data=0x000000AA, stall_out high 3 cycles.
REQ-031 Byte store, post, base_in=0x200, addr_in=0x204, data=0x5A -> dmem_addr=0x200, be=0001, wdata=0x5A5A5A5A, base_we=1, base_data=0x204.
REQ-032 Word load, addr 0x102, rdata=0x11223344 -> wb_data=0x33441122.
REQ-033 No ack for 16 cycles -> mem_fault pulse, wb_we=0, FSM in IDLE, dmem_req=0.
REQ-034 reset=0 during ACCESS -> dmem_req=0 same cycle, no wb_valid after release.
